stage_ex: RTL and testbench
===========================

Name: stage_ex

Overview:
- Execute stage of the 5-stage RV32I pipeline; the consumer of the ID/EX latch outputs (busa, busb, funct3, imm, op, pc, rd), plus funct7 carried alongside.
- Computes ALU result, branch decision and target, and store data, then registers them into EX/MEM outputs.
- Drives busy_out back to the hazard logic: busy_out low is ena_idex, and busy_out high also holds IF/ID and PC while a multi-cycle operation runs.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
MD_ITER, 32, iterations per multiply/divide; used only with the optional feature.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
busa_in  in  32  rs1 value from ID/EX
busb_in  in  32  rs2 value from ID/EX
imm_in  in  32  sign-extended immediate
funct3_in  in  3  instruction funct3
funct7_in  in  7  instruction funct7; zero for non-R-type
op_in  in  7  opcode; 7'b0000000 marks a bubble
pc_in  in  32  instruction PC
rd_in  in  5  destination register
alu_out  out  32  registered result or memory address
busb_out  out  32  registered store data
rd_out  out  5  registered rd
op_out  out  7  registered opcode
funct3_out  out  3  registered funct3
branch_taken  out  1  registered redirect request
branch_target  out  32  registered redirect PC
busy_out  out  1  combinational stall request

Behaviour:
- Reset: rst_n low clears all registered outputs to 0, FSM to IDLE, iteration count to 0, all immediately. Reset mid-operation aborts the operation; no result is written.
- Latency: single-cycle ops present their inputs in cycle N and drive the EX/MEM outputs from cycle N+1.
- Bubble (op 0000000) or an unrecognised opcode: every registered output loads 0.
- OP (0110011): ADD, or SUB when funct7[5]=1; SLL, SLT, SLTU, XOR, OR, AND. SRL, or SRA when funct7[5]=1. Shift amount is busb[4:0].
- OP-IMM (0010011): same operations with imm as operand b; no SUBI. SRAI when imm[10]=1. Shift amount is imm[4:0].
- LUI: alu_out = imm.
- AUIPC: alu_out = pc + imm.
- LOAD and STORE: alu_out = busa + imm; busb_out = busb_in for all ops.
- JAL: alu_out = pc+4; branch_taken = 1; branch_target = pc+imm.
- JALR: alu_out = pc+4; branch_taken = 1; branch_target = (busa+imm) & ~1.
- BRANCH (1100011): branch_target = pc+imm; alu_out = 0.
  - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - funct3 010 or 011: branch_taken = 0.
- Arithmetic: all arithmetic is modulo 2^32; overflow is ignored.
- FSM states: IDLE, BUSY. Without the optional feature the FSM stays in IDLE and busy_out = 0.
- busy_out while IDLE is high only when a muldiv op is presented (op 0110011, funct7 0000001).

Optional Feature:
STAGE_EX_MULDIV_EN

Defined: RV32M via an iterative shift-add multiplier and a restoring divider.
- Issue cycle C0 (muldiv op presented in IDLE): busy_out = 1. At the C0 edge, operands and funct3/rd are latched, state goes to BUSY with count 0, and outputs load a bubble.
- BUSY: all inputs are ignored (ID/EX supplies bubbles); outputs hold bubble values.
  - busy_out = 1 while count < MD_ITER-1.
  - In the cycle count = MD_ITER-1, busy_out = 0. At that edge the result is registered and the state returns to IDLE.
  - The result is visible in cycle C0+MD_ITER+1. The next instruction enters EX in the same cycle.
- MUL gives the low word; MULH, MULHSU and MULHU give the high word with the matching signedness. DIV/DIVU/REM/REMU use sign correction.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.

Undefined: funct7 0000001 under OP decodes as the base operation selected by funct3 (funct7[5]=0), single cycle, busy_out = 0.

Test Plan:
- Reset: rst_n low mid-stream -> all outputs 0 at once, busy_out 0. Release, then ADD a=5 b=7 -> alu_out 12 next cycle.
- SUB a=3 b=5 (funct7 0100000) -> alu_out 0xFFFFFFFE. SRAI a=0x80000000 imm=0x401 -> alu_out 0xC0000000.
- BLT a=0xFFFFFFFF b=1 pc=0x100 imm=0x20 -> branch_taken 1, target 0x120. BLTU with the same operands -> branch_taken 0.
- JALR a=0x203 imm=0 pc=0x40 -> alu_out 0x44, branch_target 0x202, branch_taken 1. A bubble follows -> all outputs 0.
- MULDIV_EN: MUL a=0xFFFFFFFF b=3 -> busy_out high 32 cycles, alu_out 0xFFFFFFFD at C0+33. DIV a=7 b=0 -> 0xFFFFFFFF. REM 0x80000000 % 0xFFFFFFFF -> 0.
- MULDIV_EN: reset asserted at count 10 -> IDLE, no result written, the next ADD completes normally.

Source files
------------

// File: rtl/stage_ex.sv
// stage_ex: RV32I execute stage feeding the EX/MEM latch; busy_out stalls the front end.
// Define STAGE_EX_MULDIV_EN to add the iterative RV32M multiply/divide unit.
module stage_ex #(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] busa_in,
    input  logic [XLEN-1:0] busb_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [2:0]      funct3_in,
    input  logic [6:0]      funct7_in,
    input  logic [6:0]      op_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [4:0]      rd_in,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] busb_out,
    output logic [4:0]      rd_out,
    output logic [6:0]      op_out,
    output logic [2:0]      funct3_out,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            busy_out
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;

    logic [XLEN-1:0]        opnd_b, alu_res, tgt_res, jalr_sum, srl_res;
    logic signed [XLEN-1:0] sra_res;
    logic [4:0]             shamt;
    logic                   sub_sel, sra_sel, taken_res, op_valid;
    logic                   md_req, md_issue, md_done;
    logic [XLEN-1:0]        md_result, md_busb;
    logic [4:0]             md_rd;
    logic [2:0]             md_f3;

    // Shift type comes from funct7[5] for register ops and imm[10] for immediates.
    assign opnd_b   = (op_in == OPC_OP) ? busb_in : imm_in;
    assign shamt    = opnd_b[4:0];
    assign sub_sel  = (op_in == OPC_OP) && funct7_in[5];
    assign sra_sel  = (op_in == OPC_OP) ? funct7_in[5] : imm_in[10];
    assign jalr_sum = busa_in + imm_in;
    assign sra_res  = $signed(busa_in) >>> shamt;
    assign srl_res  = busa_in >> shamt;

    always_comb begin
        alu_res   = '0;
        tgt_res   = '0;
        taken_res = 1'b0;
        op_valid  = 1'b1;
        case (op_in)
            OPC_OP, OPC_IMM: begin
                case (funct3_in)
                    3'b000:  alu_res = sub_sel ? busa_in - opnd_b : busa_in + opnd_b;
                    3'b001:  alu_res = busa_in << shamt;
                    3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(busa_in) < $signed(opnd_b)};
                    3'b011:  alu_res = {{(XLEN-1){1'b0}}, busa_in < opnd_b};
                    3'b100:  alu_res = busa_in ^ opnd_b;
                    3'b101:  alu_res = sra_sel ? sra_res : srl_res;
                    3'b110:  alu_res = busa_in | opnd_b;
                    default: alu_res = busa_in & opnd_b;
                endcase
            end
            OPC_LUI:              alu_res = imm_in;
            OPC_AUIPC:            alu_res = pc_in + imm_in;
            OPC_LOAD, OPC_STORE:  alu_res = jalr_sum;
            OPC_JAL: begin
                alu_res   = pc_in + XLEN'(4);
                taken_res = 1'b1;
                tgt_res   = pc_in + imm_in;
            end
            OPC_JALR: begin
                alu_res   = pc_in + XLEN'(4);
                taken_res = 1'b1;
                tgt_res   = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                tgt_res = pc_in + imm_in;
                case (funct3_in)
                    3'b000:  taken_res = (busa_in == busb_in);
                    3'b001:  taken_res = (busa_in != busb_in);
                    3'b100:  taken_res = ($signed(busa_in) < $signed(busb_in));
                    3'b101:  taken_res = ($signed(busa_in) >= $signed(busb_in));
                    3'b110:  taken_res = (busa_in < busb_in);
                    3'b111:  taken_res = (busa_in >= busb_in);
                    default: taken_res = 1'b0;
                endcase
            end
            default: op_valid = 1'b0;
        endcase
    end

`ifdef STAGE_EX_MULDIV_EN
    localparam int            CW      = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;
    localparam logic [CW-1:0] MD_LAST = CW'(MD_ITER - 1);

    logic [CW-1:0]     md_count;
    logic [2*XLEN-1:0] md_acc, md_acc_n, md_prod;
    logic [XLEN-1:0]   md_opnd, mag_a, mag_b;
    logic [XLEN:0]     md_sum, md_rsh;
    logic              md_neg, md_rneg, sgn_a, sgn_b;

    assign md_req = (op_in == OPC_OP) && (funct7_in == 7'b0000001);
    assign sgn_a  = busa_in[XLEN-1] && (funct3_in inside {3'b001, 3'b010, 3'b100, 3'b110});
    assign sgn_b  = busb_in[XLEN-1] && (funct3_in inside {3'b001, 3'b100, 3'b110});
    assign mag_a  = sgn_a ? -busa_in : busa_in;
    assign mag_b  = sgn_b ? -busb_in : busb_in;

    // md_acc is {hi, lo}: shift-add product for multiply, {remainder, quotient} for divide.
    always_comb begin
        md_sum = {1'b0, md_acc[2*XLEN-1:XLEN]} + (md_acc[0] ? {1'b0, md_opnd} : '0);
        md_rsh = md_acc[2*XLEN-1:XLEN-1];
        if (md_f3[2]) begin
            if (md_rsh >= {1'b0, md_opnd})
                md_acc_n = {md_rsh[XLEN-1:0] - md_opnd, md_acc[XLEN-2:0], 1'b1};
            else
                md_acc_n = {md_rsh[XLEN-1:0], md_acc[XLEN-2:0], 1'b0};
        end else begin
            md_acc_n = {md_sum, md_acc[XLEN-1:1]};
        end
        md_prod = md_neg ? -md_acc_n : md_acc_n;
        case (md_f3)
            3'b000:                 md_result = md_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_result = md_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_result = md_neg ? -md_acc_n[XLEN-1:0] : md_acc_n[XLEN-1:0];
            default:                md_result = md_rneg ? -md_acc_n[2*XLEN-1:XLEN]
                                                        : md_acc_n[2*XLEN-1:XLEN];
        endcase
    end

    // Divide by zero keeps the quotient positive so it reads back as all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_count <= '0;
            md_acc   <= '0;
            md_opnd  <= '0;
            md_neg   <= 1'b0;
            md_rneg  <= 1'b0;
            md_f3    <= '0;
            md_rd    <= '0;
            md_busb  <= '0;
        end else if (md_issue) begin
            md_count <= '0;
            md_f3    <= funct3_in;
            md_rd    <= rd_in;
            md_busb  <= busb_in;
            md_acc   <= {{XLEN{1'b0}}, funct3_in[2] ? mag_a : mag_b};
            md_opnd  <= funct3_in[2] ? mag_b : mag_a;
            md_neg   <= (sgn_a ^ sgn_b) && !(funct3_in[2] && (busb_in == '0));
            md_rneg  <= sgn_a;
        end else if (state == BUSY) begin
            md_count <= md_count + 1'b1;
            md_acc   <= md_acc_n;
        end
    end
`else
    logic unused_funct7;

    assign md_req        = 1'b0;
    assign md_result     = '0;
    assign md_busb       = '0;
    assign md_rd         = '0;
    assign md_f3         = '0;
    assign unused_funct7 = ^{funct7_in[6], funct7_in[4:0]};
`endif

    always_comb begin
        state_n  = state;
        busy_out = 1'b0;
        md_issue = 1'b0;
        md_done  = 1'b0;
        case (state)
            IDLE: begin
                if (md_req) begin
                    busy_out = 1'b1;
                    md_issue = 1'b1;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
`ifdef STAGE_EX_MULDIV_EN
                busy_out = (md_count != MD_LAST);
                if (md_count == MD_LAST) begin
                    md_done = 1'b1;
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // A muldiv issue, the busy window and any bubble/unknown opcode all load a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out       <= '0;
            busb_out      <= '0;
            rd_out        <= '0;
            op_out        <= '0;
            funct3_out    <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (md_done) begin
            alu_out       <= md_result;
            busb_out      <= md_busb;
            rd_out        <= md_rd;
            op_out        <= OPC_OP;
            funct3_out    <= md_f3;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (md_issue || (state == BUSY) || !op_valid) begin
            alu_out       <= '0;
            busb_out      <= '0;
            rd_out        <= '0;
            op_out        <= '0;
            funct3_out    <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            alu_out       <= alu_res;
            busb_out      <= busb_in;
            rd_out        <= rd_in;
            op_out        <= op_in;
            funct3_out    <= funct3_in;
            branch_taken  <= taken_res;
            branch_target <= tgt_res;
        end
    end

endmodule

// File: tb/tb_stage_ex.sv
// tb_stage_ex: scoreboard bench for stage_ex; muldiv checks are built when STAGE_EX_MULDIV_EN is defined.
`timescale 1ns/1ps
module tb_stage_ex;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] busa_in, busb_in, imm_in, pc_in;
    logic [2:0]  funct3_in;
    logic [6:0]  funct7_in, op_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_out, busb_out, branch_target;
    logic [4:0]  rd_out;
    logic [6:0]  op_out;
    logic [2:0]  funct3_out;
    logic        branch_taken, busy_out;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] busb;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stage_ex #(.XLEN(32), .MD_ITER(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .busa_in(busa_in), .busb_in(busb_in), .imm_in(imm_in),
        .funct3_in(funct3_in), .funct7_in(funct7_in), .op_in(op_in),
        .pc_in(pc_in), .rd_in(rd_in),
        .alu_out(alu_out), .busb_out(busb_out), .rd_out(rd_out), .op_out(op_out),
        .funct3_out(funct3_out), .branch_taken(branch_taken),
        .branch_target(branch_target), .busy_out(busy_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] alu, input logic [31:0] busb,
                                   input logic [4:0] rd, input logic [6:0] op,
                                   input logic [2:0] f3, input logic taken,
                                   input logic [31:0] tgt);
        exp_t e;
        e.alu = alu; e.busb = busb; e.rd = rd; e.op = op;
        e.f3 = f3; e.taken = taken; e.tgt = tgt;
        return e;
    endfunction

    task automatic driveInputs(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [4:0] rd);
        op_in = op; funct3_in = f3; funct7_in = f7;
        busa_in = a; busb_in = b; imm_in = imm; pc_in = pc; rd_in = rd;
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                 input logic [31:0] pc, input logic [4:0] rd, input exp_t e);
        driveInputs(op, f3, f7, a, b, imm, pc, rd);
        exp_q.push_back(e);
    endtask

    // Sample just after the edge on which the pending result is registered.
    task automatic collectResult(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput({tag, ".sb_underflow"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        checkOutput({tag, ".alu_out"},       alu_out,       e.alu);
        checkOutput({tag, ".busb_out"},      busb_out,      e.busb);
        checkOutput({tag, ".rd_out"},        rd_out,        e.rd);
        checkOutput({tag, ".op_out"},        op_out,        e.op);
        checkOutput({tag, ".funct3_out"},    funct3_out,    e.f3);
        checkOutput({tag, ".branch_taken"},  branch_taken,  e.taken);
        checkOutput({tag, ".branch_target"}, branch_target, e.tgt);
        checkOutput({tag, ".busy_out"},      busy_out,      1'b0);
    endtask

    task automatic runOp(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] ealu, input logic etk, input logic [31:0] etgt);
        applyStimulus(op, f3, f7, a, b, imm, pc, rd, mkExp(ealu, b, rd, op, f3, etk, etgt));
        collectResult(tag);
    endtask

    task automatic runZero(input string tag, input logic [6:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc);
        applyStimulus(op, 3'b010, 7'b0100000, a, b, 32'h10, pc, 5'd3,
                      mkExp(32'd0, 32'd0, 5'd0, 7'd0, 3'd0, 1'b0, 32'd0));
        collectResult(tag);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".alu_out"},       alu_out,       32'd0);
        checkOutput({tag, ".busb_out"},      busb_out,      32'd0);
        checkOutput({tag, ".rd_out"},        rd_out,        32'd0);
        checkOutput({tag, ".op_out"},        op_out,        32'd0);
        checkOutput({tag, ".funct3_out"},    funct3_out,    32'd0);
        checkOutput({tag, ".branch_taken"},  branch_taken,  32'd0);
        checkOutput({tag, ".branch_target"}, branch_target, 32'd0);
        checkOutput({tag, ".busy_out"},      busy_out,      32'd0);
    endtask

`ifdef STAGE_EX_MULDIV_EN
    task automatic runMulDiv(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic [31:0] eres);
        int busy_cycles;
        int guard;
        applyStimulus(OPC_OP, f3, 7'b0000001, a, b, 32'd0, 32'd0, rd,
                      mkExp(eres, b, rd, OPC_OP, f3, 1'b0, 32'd0));
        #1;
        checkOutput({tag, ".busy_c0"}, busy_out, 1'b1);
        busy_cycles = 1;
        @(posedge clk);
        #1;
        driveInputs(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        checkOutput({tag, ".hold_alu"}, alu_out, 32'd0);
        checkOutput({tag, ".hold_op"},  op_out,  32'd0);
        guard = 0;
        while (busy_out && guard < 40) begin
            busy_cycles++;
            guard++;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, ".busy_len"}, busy_cycles, 32'd32);
        collectResult(tag);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        driveInputs(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while a valid result sits on the outputs.
        runOp("pre_rst", OPC_OP, 3'b000, 7'd0, 32'd9, 32'd9, 32'd0, 32'd0, 5'd4, 32'd18, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;

        runOp("add",   OPC_OP, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd1, 32'd12, 1'b0, 32'd0);
        runOp("sub",   OPC_OP, 3'b000, 7'h20, 32'd3, 32'd5, 32'd0, 32'd0, 5'd2, 32'hFFFFFFFE, 1'b0, 32'd0);
        runOp("sll",   OPC_OP, 3'b001, 7'h00, 32'd1, 32'h24, 32'd0, 32'd0, 5'd3, 32'h10, 1'b0, 32'd0);
        runOp("slt",   OPC_OP, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd4, 32'd1, 1'b0, 32'd0);
        runOp("sltu",  OPC_OP, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd5, 32'd0, 1'b0, 32'd0);
        runOp("xor",   OPC_OP, 3'b100, 7'h00, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 5'd6, 32'hFF00, 1'b0, 32'd0);
        runOp("srl",   OPC_OP, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd7, 32'h08000000, 1'b0, 32'd0);
        runOp("sra",   OPC_OP, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd8, 32'hF8000000, 1'b0, 32'd0);
        runOp("or",    OPC_OP, 3'b110, 7'h00, 32'hF000, 32'h000F, 32'd0, 32'd0, 5'd9, 32'hF00F, 1'b0, 32'd0);
        runOp("and",   OPC_OP, 3'b111, 7'h00, 32'hFF00, 32'h0FF0, 32'd0, 32'd0, 5'd10, 32'h0F00, 1'b0, 32'd0);
        runOp("addi",  OPC_IMM, 3'b000, 7'h00, 32'd10, 32'h55, 32'hFFFFFFFF, 32'd0, 5'd11, 32'd9, 1'b0, 32'd0);
        runOp("srai",  OPC_IMM, 3'b101, 7'h00, 32'h80000000, 32'd0, 32'h401, 32'd0, 5'd12, 32'hC0000000, 1'b0, 32'd0);
        runOp("srli",  OPC_IMM, 3'b101, 7'h00, 32'h80000000, 32'd0, 32'h001, 32'd0, 5'd13, 32'h40000000, 1'b0, 32'd0);
        runOp("sltiu", OPC_IMM, 3'b011, 7'h00, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd14, 32'd1, 1'b0, 32'd0);
        runOp("lui",   OPC_LUI, 3'b000, 7'h00, 32'h999, 32'd0, 32'h12345000, 32'd0, 5'd15, 32'h12345000, 1'b0, 32'd0);
        runOp("auipc", OPC_AUIPC, 3'b000, 7'h00, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd16, 32'h3000, 1'b0, 32'd0);
        runOp("load",  OPC_LOAD, 3'b010, 7'h00, 32'h100, 32'd0, 32'hFFFFFFFC, 32'd0, 5'd17, 32'hFC, 1'b0, 32'd0);
        runOp("store", OPC_STORE, 3'b010, 7'h00, 32'h200, 32'hDEADBEEF, 32'd8, 32'd0, 5'd0, 32'h208, 1'b0, 32'd0);
        runOp("jal",   OPC_JAL, 3'b000, 7'h00, 32'd0, 32'd0, 32'h10, 32'h80, 5'd1, 32'h84, 1'b1, 32'h90);
        runOp("jalr",  OPC_JALR, 3'b000, 7'h00, 32'h203, 32'd0, 32'd0, 32'h40, 5'd1, 32'h44, 1'b1, 32'h202);
        runZero("bubble", 7'd0, 32'd5, 32'd6, 32'h44);
        runOp("blt",   OPC_BRANCH, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 5'd0, 32'd0, 1'b1, 32'h120);
        runOp("bltu",  OPC_BRANCH, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 5'd0, 32'd0, 1'b0, 32'h120);
        runOp("beq",   OPC_BRANCH, 3'b000, 7'h00, 32'd7, 32'd7, 32'h8, 32'h200, 5'd0, 32'd0, 1'b1, 32'h208);
        runOp("bne",   OPC_BRANCH, 3'b001, 7'h00, 32'd7, 32'd7, 32'h8, 32'h200, 5'd0, 32'd0, 1'b0, 32'h208);
        runOp("bge",   OPC_BRANCH, 3'b101, 7'h00, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h300, 5'd0, 32'd0, 1'b1, 32'h2F0);
        runOp("bgeu",  OPC_BRANCH, 3'b111, 7'h00, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h300, 5'd0, 32'd0, 1'b0, 32'h2F0);
        runOp("br_f3_010", OPC_BRANCH, 3'b010, 7'h00, 32'd7, 32'd7, 32'h4, 32'h400, 5'd0, 32'd0, 1'b0, 32'h404);
        runZero("unknown_op", 7'b1111111, 32'd5, 32'd5, 32'h48);

`ifdef STAGE_EX_MULDIV_EN
        runMulDiv("mul",    3'b000, 32'hFFFFFFFF, 32'd3, 5'd20, 32'hFFFFFFFD);
        runMulDiv("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'hFFFFFFFE);
        runMulDiv("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd22, 32'd0);
        runMulDiv("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd3, 5'd23, 32'hFFFFFFFF);
        runMulDiv("div0",   3'b100, 32'd7, 32'd0, 5'd24, 32'hFFFFFFFF);
        runMulDiv("rem0",   3'b110, 32'hFFFFFFF9, 32'd0, 5'd25, 32'hFFFFFFF9);
        runMulDiv("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd26, 32'd0);
        runMulDiv("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd27, 32'h80000000);
        runMulDiv("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd28, 32'hFFFFFFFD);
        runMulDiv("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd29, 32'hFFFFFFFF);
        runMulDiv("divu",   3'b101, 32'd100, 32'd7, 5'd30, 32'd14);
        runMulDiv("remu",   3'b111, 32'd100, 32'd7, 5'd31, 32'd2);
        runOp("after_md", OPC_OP, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1, 32'd3, 1'b0, 32'd0);

        // Reset at iteration count 10 must abort with no result written.
        driveInputs(OPC_OP, 3'b000, 7'b0000001, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, 5'd9);
        @(posedge clk);
        #1;
        driveInputs(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort.busy_mid", busy_out, 1'b1);
        rst_n = 1'b0;
        #1;
        checkAllZero("abort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        checkAllZero("abort_quiet");
        runOp("abort_add", OPC_OP, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd1, 32'd12, 1'b0, 32'd0);
`else
        runOp("m_as_add", OPC_OP, 3'b000, 7'b0000001, 32'd2, 32'd3, 32'd0, 32'd0, 5'd5, 32'd5, 1'b0, 32'd0);
        runOp("m_as_xor", OPC_OP, 3'b100, 7'b0000001, 32'hF0, 32'hFF, 32'd0, 32'd0, 5'd6, 32'h0F, 1'b0, 32'd0);
`endif

        runZero("final_bubble", 7'd0, 32'd1, 32'd1, 32'd0);
        checkOutput("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
